nibble_serial_add_ctrl: RTL and testbench

//   Sequences one shared Adder_4_Bit ripple-carry adder to add or subtract WIDTH-bit operands one nibble per cycle, LSB nibble first.
//   The carry is registered between nibbles.
//   The block sits between a valid/ready operand source and a valid/ready result sink.
//   The adder is external: this block drives its A/B/Cin and samples its S/Cout in the same cycle.

---
 rtl/nibble_serial_add_ctrl.sv | 119 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial add/sub sequencer for an external 4-bit ripple adder
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [3:0]       o_add_a,
  output logic [3:0]       o_add_b,
  output logic             o_add_cin,
  input  logic [3:0]       i_add_s,
  input  logic             i_add_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [WIDTH-1:0] w_sum_next;
  logic [IW+1:0]    w_shift;
  logic             w_run;

  assign w_run   = (r_state == S_RUN);
  assign w_shift = {r_idx, 2'b00};
  assign w_a_sh  = r_a >> w_shift;
  assign w_b_sh  = r_b >> w_shift;

  // Merge the adder's nibble into the working sum at the current position.
  assign w_sum_next = (r_sum & ~({{(WIDTH-4){1'b0}}, 4'hF} << w_shift))
                    | ({{(WIDTH-4){1'b0}}, i_add_s} << w_shift);

  assign o_add_a     = w_run ? w_a_sh[3:0] : 4'h0;
  assign o_add_b     = w_run ? w_b_sh[3:0] : 4'h0;
  assign o_add_cin   = w_run ? r_carry : 1'b0;
  assign o_in_ready  = (r_state == S_IDLE) && rst_n;
  assign o_out_valid = r_out_valid;
  assign o_s         = r_s;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            // Subtraction is A + ~B + ~borrow, so B and the carry are inverted once at capture.
            r_a     <= i_a;
            r_b     <= i_op ? ~i_b : i_b;
            r_carry <= i_cin ^ i_op;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= i_add_cout;
          if (r_idx == LAST) begin
            r_idx       <= '0;
            r_s         <= w_sum_next;
            r_cout      <= i_add_cout;
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (i_add_s[3] != r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for nibble_serial_add_ctrl with a behavioural 4-bit adder
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .i_cin      (cin),
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .o_add_cin  (add_cin),
    .i_add_s    (add_s),
    .i_add_cout (add_cout),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_s        (s),
    .o_cout     (cout),
    .o_ovf      (ovf)
  );

  // Behavioural stand-in for the external Adder_4_Bit.
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic o_p, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic ci);
    exp_t             e;
    logic [WIDTH-1:0] ye;
    logic [WIDTH:0]   r;
    ye  = o_p ? ~y : y;
    r   = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, ci ^ o_p};
    e.s = r[WIDTH-1:0];
    e.c = r[WIDTH];
    e.o = (x[WIDTH-1] == ye[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the result handshake.
  task automatic do_op(input string tag, input logic o_p, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic ci, input int hold, input bit chk_cin);
    int               cnt;
    logic             cins [NIB];
    exp_t             e;
    logic [WIDTH-1:0] hs;
    logic             hc;
    logic             ho;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    op = o_p; a = x; b = y; cin = ci; in_valid = 1'b1;
    sb.push_back(model(o_p, x, y, ci));
    @(negedge clk);
    if (hold > 0) begin
      a = 16'hDEAD; b = 16'hBEEF; out_ready = 1'b0;
    end else begin
      in_valid = 1'b0;
    end
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      if (cnt < NIB) cins[cnt] = add_cin;
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, cnt, NIB);
    if (chk_cin) begin
      for (int i = 1; i < NIB; i++) chk({tag, "_add_cin_step"}, cins[i], 1);
    end
    chk({tag, "_in_ready_done"}, in_ready, 0);
    if (hold > 0) begin
      hs = s; hc = cout; ho = ovf;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_ready"}, in_ready, 0);
        chk({tag, "_hold_s"}, s, hs);
        chk({tag, "_hold_cout_ovf"}, {cout, ovf}, {hc, ho});
      end
      out_ready = 1'b1;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_s"}, s, e.s);
      chk({tag, "_cout"}, cout, e.c);
      chk({tag, "_ovf"}, ovf, e.o);
    end
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {s, cout, ovf}, 0);
    chk("rst_add_bus", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);

    do_op("t1_add", 1'b0, 16'h1234, 16'h0001, 1'b0, 0, 1'b0);
    do_op("t2_ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b1);
    do_op("t3_ovf", 1'b0, 16'h7FFF, 16'h0000, 1'b1, 0, 1'b0);
    do_op("t4_sub", 1'b1, 16'h0005, 16'h0007, 1'b0, 0, 1'b0);
    do_op("t4_subovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    do_op("t5_hold", 1'b0, 16'hA5A5, 16'h1111, 1'b1, 5, 1'b0);
    do_op("t5_next", 1'b1, 16'h0100, 16'h0001, 1'b1, 0, 1'b0);

    op = 1'b0; a = 16'h1234; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_in_run", add_a, 4'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_outputs", {s, cout, ovf}, 0);
    chk("t6_rst_add_bus", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_valid", out_valid, 0);
    end
    do_op("t6_repeat", 1'b0, 16'h1234, 16'h0001, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
